mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
- Multiply/divide sequencer for the HI/LO register pair. Sits beside the EX stage.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO, runs the multi-cycle operation, then issues one write to HI/LO.
- Stalls the pipeline while busy or when an MFHI/MFLO would read stale HI/LO.
- Supports cancel on exception flush.

Parameters:
- MUL_LAT, 2, cycles spent in MUL state (allowed range 1..4); product computed from operands registered at acceptance.
- DIV_ITER, 32, restoring-divider iterations; fixed at 32 for 32-bit operands.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- op_valid  in  1  EX-stage MDU instruction present.
- op_code  in  3  opcode (see package).
- op_a  in  32  rs value / dividend / MTxx source.
- op_b  in  32  rt value / divisor.
- cancel  in  1  flush: abort in-flight op, suppress its write.
- mf_req  in  1  MFHI/MFLO present in EX.
- op_ready  out  1  high iff state==IDLE.
- busy  out  1  high iff state!=IDLE.
- stall  out  1  pipeline hold request.
- hi_wen  out  1  HI write enable.
- lo_wen  out  1  LO write enable.
- hi_wdata  out  32  HI write data.
- lo_wdata  out  32  LO write data.

Behaviour:
- Reset (async, rst=1): state=IDLE; all operand, result and counter registers cleared; hi_wen=lo_wen=0, hi_wdata=lo_wdata=0, busy=0, stall=0. Reset mid-op discards the op; no write occurs.
- States: IDLE, MUL, DIV, WB.
- Acceptance: in cycle 0, when op_valid & op_ready & !cancel with a legal opcode. At acceptance, op_a, op_b and op_code are latched.
- Transitions out of IDLE on acceptance:
  - MULT/MULTU -> MUL.
  - DIV/DIVU -> DIV.
  - MTHI/MTLO -> WB.
- Reserved opcodes (6, 7) are never accepted; state stays IDLE.
- MUL: counts MUL_LAT cycles, then -> WB. 64-bit product is signed for MULT, unsigned for MULTU. HI=product[63:32], LO=product[31:0].
- DIV: computed on magnitudes in the divider core, one quotient bit per cycle, DIV_ITER cycles, then -> WB.
  - Signed (DIV): quotient is negated if the operand signs differ; remainder takes the dividend's sign.
  - 0x80000000 / -1 yields LO=0x80000000, HI=0.
  - Divide by zero (DIV or DIVU): LO=0xFFFFFFFF, HI=op_a unchanged.
  - LO=quotient, HI=remainder.
- WB: lasts exactly one cycle, then -> IDLE.
  - MUL/DIV: hi_wen=lo_wen=1.
  - MTHI: hi_wen=1 only, hi_wdata=op_a.
  - MTLO: lo_wen=1 only, lo_wdata=op_a.
  - Write enables are asserted only in WB.
- Latency from acceptance cycle 0 to the WB cycle:
  - MTxx: WB in cycle 1.
  - MUL: WB in cycle MUL_LAT+1.
  - DIV: WB in cycle 33.
  - op_ready returns high the cycle after WB.
- Outputs: registered state; wen and wdata are driven from registered result/state, with no combinational path from op_*. op_ready and busy are combinational from state. stall may be combinational from inputs.
- stall = (mf_req & busy) | (op_valid & !op_ready).
  - Includes the WB cycle, because HI/LO update only at the end of WB.
  - Drops in the first IDLE cycle.
- cancel:
  - In IDLE: blocks acceptance; cancel wins over op_valid.
  - In MUL/DIV: next state IDLE, no write.
  - In WB: hi_wen/lo_wen are forced to 0 that cycle.
- Back-to-back ops: a new op is accepted only in IDLE, so there is a minimum one-cycle gap after WB.

Decomposition:
- Package mdu_pkg holds:
  - op codes: OP_MULT=0, OP_MULTU=1, OP_DIV=2, OP_DIVU=3, OP_MTHI=4, OP_MTLO=5.
  - state encoding: IDLE=0, MUL=1, DIV=2, WB=3.
  - DIV_ITER.
- Sub-module mdu_div_iter: 32-bit unsigned restoring divider core.
  - Ports: start, dividend, divisor, done, quotient, remainder.
  - Sign fix-up and the divide-by-zero result stay in mdu_ctrl.

Test Plan:
1. MULT a=0xFFFFFFFF, b=2 -> in WB cycle (MUL_LAT+1): hi_wen=lo_wen=1, HI=0xFFFFFFFF, LO=0xFFFFFFFE. Same operands with MULTU -> HI=0x00000001, LO=0xFFFFFFFE.
2. DIV a=0xFFFFFFF9 (-7), b=2 -> cycle 33: LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 -> LO=3, HI=1. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
3. DIVU a=5, b=0 -> LO=0xFFFFFFFF, HI=5.
4. DIV accepted, then cancel=1 in cycle 10 -> no wen ever asserted for this op; op_ready=1 in cycle 11; a following MTLO 0xA5A5A5A5 is accepted and produces only lo_wen with data 0xA5A5A5A5 one cycle later.
5. mf_req=1 held during a DIV -> stall=1 through the WB cycle (cycle 33) and 0 in cycle 34. op_valid with MTHI during busy -> stall=1, not accepted until IDLE.
6. rst asserted asynchronously mid-MUL -> immediately busy=0, hi_wen=lo_wen=0, data outputs 0; no write after rst is released.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared opcode and state encodings plus small helpers for the HI/LO
// multiply/divide sequencer.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    WB   = 2'd3
  } state_e;

  localparam int DIV_ITER = 32;

  // Opcodes 6 and 7 are reserved and must never be accepted.
  function automatic logic op_legal(input logic [2:0] code);
    return code <= 3'd5;
  endfunction

  // Magnitude of a value, treating it as two's complement only when signed.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// 32-bit unsigned restoring divider: one quotient bit per cycle. The first
// iteration happens on the start edge so the result is ready DIV_ITER cycles
// after start is sampled, with done pulsing in the cycle it becomes readable.
module mdu_div_iter
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] r_quo;
  logic [31:0] r_rem;
  logic [31:0] r_dvs;
  logic [5:0]  r_cnt;
  logic        r_run;

  logic [31:0] w_rem_in;
  logic [31:0] w_quo_in;
  logic [31:0] w_dvs;
  logic [32:0] w_shift;
  logic        w_ge;
  logic [31:0] w_rem_nxt;
  logic [31:0] w_quo_nxt;

  // One restoring step, fed from fresh operands on start or from the registers.
  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path; the muxes below cover all cases, so no latch is inferred.
    w_rem_in  = start ? 32'd0    : r_rem;
    w_quo_in  = start ? dividend : r_quo;
    w_dvs     = start ? divisor  : r_dvs;
    w_shift   = {w_rem_in, w_quo_in[31]};
    w_ge      = (w_shift >= {1'b0, w_dvs});
    w_rem_nxt = w_ge ? (w_shift[31:0] - w_dvs) : w_shift[31:0];
    w_quo_nxt = {w_quo_in[30:0], w_ge};
  end

  // Iteration registers: load-and-step on start, then step until the count runs out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: every datapath register is cleared by reset so no stale operand or partial result survives it.
      r_quo <= '0;
      r_rem <= '0;
      r_dvs <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (start) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      r_quo <= w_quo_nxt;
      r_rem <= w_rem_nxt;
      r_dvs <= divisor;
      r_cnt <= 6'(DIV_ITER - 1);
      r_run <= 1'b1;
    end else if (r_run) begin
      if (r_cnt != 6'd0) begin
        r_quo <= w_quo_nxt;
        r_rem <= w_rem_nxt;
        r_cnt <= r_cnt - 6'd1;
      end else begin
        r_run <= 1'b0;
      end
    end
  end

  assign done      = r_run && (r_cnt == 6'd0);
  assign quotient  = r_quo;
  assign remainder = r_rem;

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer for the HI/LO pair: accepts one MDU op in IDLE,
// runs it, issues a single registered HI/LO write in WB, and requests a
// pipeline stall while busy or while an MFHI/MFLO would read stale data.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        cancel,
  input  logic        mf_req,
  output logic        op_ready,
  output logic        busy,
  output logic        stall,
  output logic        hi_wen,
  output logic        lo_wen,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata
);

  state_e      r_state;
  state_e      w_next;
  op_e         r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [2:0]  r_mcnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_wr_hi;
  logic        r_wr_lo;

  logic        w_accept;
  logic        w_div_start;
  logic        w_div_signed;
  logic        w_div_done;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic        w_mul_signed;
  logic [63:0] w_prod;
  logic        w_neg_q;
  logic        w_neg_r;

  assign w_accept     = op_valid && (r_state == IDLE) && !cancel && op_legal(op_code);
  assign w_div_signed = (op_code == OP_DIV);
  assign w_div_start  = w_accept && ((op_code == OP_DIV) || (op_code == OP_DIVU));

  mdu_div_iter u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (w_div_start),
    .dividend  (mag32(op_a, w_div_signed)),
    .divisor   (mag32(op_b, w_div_signed)),
    .done      (w_div_done),
    .quotient  (w_quo),
    .remainder (w_rem)
  );

  // Product of the latched operands; sign-extension selects MULT vs MULTU.
  assign w_mul_signed = (r_op == OP_MULT);
  assign w_prod = {{32{w_mul_signed & r_a[31]}}, r_a} * {{32{w_mul_signed & r_b[31]}}, r_b};

  // Sign fix-up for DIV: quotient negated on differing signs, remainder follows dividend.
  assign w_neg_q = (r_op == OP_DIV) && (r_a[31] ^ r_b[31]);
  assign w_neg_r = (r_op == OP_DIV) && r_a[31];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state and write-enable decode.
  always_comb begin
    w_next = r_state;
    hi_wen = 1'b0;
    lo_wen = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          case (op_e'(op_code))
            OP_MULT, OP_MULTU: w_next = MUL;
            OP_DIV, OP_DIVU:   w_next = DIV;
            default:           w_next = WB;
          endcase
        end
      end
      MUL: begin
        if (cancel)                 w_next = IDLE;
        else if (r_mcnt == 3'd0)    w_next = WB;
      end
      DIV: begin
        if (cancel)                 w_next = IDLE;
        else if (w_div_done)        w_next = WB;
      end
      WB: begin
        w_next = IDLE;
        hi_wen = r_wr_hi && !cancel;
        lo_wen = r_wr_lo && !cancel;
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand latch, MUL countdown and HI/LO result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op    <= OP_MULT;
      r_a     <= '0;
      r_b     <= '0;
      r_mcnt  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_wr_hi <= 1'b0;
      r_wr_lo <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op    <= op_e'(op_code);
        r_a     <= op_a;
        r_b     <= op_b;
        r_mcnt  <= 3'(MUL_LAT - 1);
        r_wr_hi <= (op_code != OP_MTLO);
        r_wr_lo <= (op_code != OP_MTHI);
        if (op_code == OP_MTHI) r_hi <= op_a;
        if (op_code == OP_MTLO) r_lo <= op_a;
      end
      if ((r_state == MUL) && (r_mcnt != 3'd0)) r_mcnt <= r_mcnt - 3'd1;
      if ((r_state == MUL) && (w_next == WB)) begin
        r_hi <= w_prod[63:32];
        r_lo <= w_prod[31:0];
      end
      if ((r_state == DIV) && (w_next == WB)) begin
        if (r_b == 32'd0) begin
          r_hi <= r_a;
          r_lo <= 32'hFFFF_FFFF;
        end else begin
          r_hi <= w_neg_r ? (~w_rem + 32'd1) : w_rem;
          r_lo <= w_neg_q ? (~w_quo + 32'd1) : w_quo;
        end
      end
    end
  end

  assign op_ready = (r_state == IDLE);
  assign busy     = (r_state != IDLE);
  assign stall    = (mf_req && busy) || (op_valid && !op_ready);
  assign hi_wdata = r_hi;
  assign lo_wdata = r_lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: stimulus pushes expected HI/LO writes
// (value and cycle) computed by an arithmetic reference model; a monitor
// pops and compares whenever the DUT raises a write enable.
module tb_mdu_ctrl;

  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        cancel;
  logic        mf_req;
  logic        op_ready;
  logic        busy;
  logic        stall;
  logic        hi_wen;
  logic        lo_wen;
  logic [31:0] hi_wdata;
  logic [31:0] lo_wdata;

  typedef struct {
    int          wb_cyc;
    bit          hw;
    bit          lw;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  mdu_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .op_code  (op_code),
    .op_a     (op_a),
    .op_b     (op_b),
    .cancel   (cancel),
    .mf_req   (mf_req),
    .op_ready (op_ready),
    .busy     (busy),
    .stall    (stall),
    .hi_wen   (hi_wen),
    .lo_wen   (lo_wen),
    .hi_wdata (hi_wdata),
    .lo_wdata (lo_wdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: HI/LO result from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input int op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb_, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb_ = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      0: return 64'(sa * sb_);
      1: return ua * ub;
      2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb_;
        r = sa % sb_;
        return {r[31:0], q[31:0]};
      end
      3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      4: return {a, 32'd0};
      default: return {32'd0, a};
    endcase
  endfunction

  // Expected write for an op accepted in the current cycle.
  task automatic push_exp(input int op, input logic [31:0] a, input logic [31:0] b, output int lat);
    exp_t        e;
    logic [63:0] m;
    lat = (op <= 1) ? MUL_LAT + 1 : (op <= 3) ? 33 : 1;
    m = model(op, a, b);
    e.wb_cyc = cyc + lat;
    e.hw = (op != 5);
    e.lw = (op != 4);
    e.hi = m[63:32];
    e.lo = m[31:0];
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one legal op while idle and follow it to completion.
  task automatic issue(input int op, input logic [31:0] a, input logic [31:0] b);
    int lat;
    op_valid = 1'b1;
    op_code  = 3'(op);
    op_a     = a;
    op_b     = b;
    push_exp(op, a, b, lat);
    tick();
    op_valid = 1'b0;
    op_a     = $urandom;
    op_b     = $urandom;
    @(negedge clk);
    check("busy_after_accept", {63'd0, busy}, 64'd1);
    repeat (lat) tick();
    @(negedge clk);
    check("ready_after_wb", {63'd0, op_ready}, 64'd1);
  endtask

  // Monitor: every write enable must match the head of the scoreboard.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].wb_cyc < cyc) begin
      check("missed_write_cycle", 64'(cyc), 64'(sb[0].wb_cyc));
      void'(sb.pop_front());
    end
    if (hi_wen || lo_wen) begin
      if (sb.size() == 0) begin
        check("unexpected_write", {62'd0, hi_wen, lo_wen}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wb_cycle", 64'(cyc), 64'(e.wb_cyc));
        check("wen_pair", {62'd0, hi_wen, lo_wen}, {62'd0, e.hw, e.lw});
        if (e.hw) check("hi_wdata", {32'd0, hi_wdata}, {32'd0, e.hi});
        if (e.lw) check("lo_wdata", {32'd0, lo_wdata}, {32'd0, e.lo});
      end
    end
  end

  initial begin
    int          c;
    int          lat;
    int          op;
    logic [31:0] a, b;

    rst = 1'b1;
    op_valid = 1'b0;
    op_code = 3'd0;
    op_a = '0;
    op_b = '0;
    cancel = 1'b0;
    mf_req = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_op_ready", {63'd0, op_ready}, 64'd1);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_stall", {63'd0, stall}, 64'd0);
    check("rst_wen", {62'd0, hi_wen, lo_wen}, 64'd0);
    check("rst_wdata", {hi_wdata, lo_wdata}, 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Directed arithmetic cases.
    issue(0, 32'hFFFF_FFFF, 32'd2);
    issue(1, 32'hFFFF_FFFF, 32'd2);
    issue(2, 32'hFFFF_FFF9, 32'd2);
    issue(3, 32'd7, 32'd2);
    issue(2, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(3, 32'd5, 32'd0);
    issue(2, 32'hFFFF_1234, 32'd0);
    issue(4, 32'h1357_9BDF, 32'd0);
    issue(5, 32'h2468_ACE0, 32'd0);

    // Cancel during DIV: no write, ready the next cycle, then an MTLO.
    op_valid = 1'b1;
    op_code  = 3'd2;
    op_a     = 32'd1000;
    op_b     = 32'd3;
    tick();
    op_valid = 1'b0;
    repeat (9) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    @(negedge clk);
    check("ready_after_cancel", {63'd0, op_ready}, 64'd1);
    issue(5, 32'hA5A5_A5A5, 32'd0);

    // Cancel in WB suppresses the write.
    op_valid = 1'b1;
    op_code  = 3'd4;
    op_a     = 32'hDEAD_BEEF;
    tick();
    op_valid = 1'b0;
    cancel = 1'b1;
    @(negedge clk);
    check("cancel_wb_wen", {62'd0, hi_wen, lo_wen}, 64'd0);
    tick();
    cancel = 1'b0;
    @(negedge clk);
    check("ready_after_wb_cancel", {63'd0, op_ready}, 64'd1);

    // Stall with mf_req across a DIV, and MTHI held until IDLE.
    c = cyc;
    op_valid = 1'b1;
    op_code  = 3'd2;
    op_a     = 32'd100;
    op_b     = 32'd7;
    push_exp(2, 32'd100, 32'd7, lat);
    tick();
    op_valid = 1'b0;
    mf_req = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      if (k == 5) begin
        op_valid = 1'b1;
        op_code  = 3'd4;
        op_a     = 32'hCAFE_0001;
      end
      @(negedge clk);
      check("stall_while_busy", {63'd0, stall}, 64'd1);
      tick();
    end
    @(negedge clk);
    check("stall_drop_cycle", 64'(cyc - c), 64'd34);
    check("stall_after_wb", {63'd0, stall}, 64'd0);
    check("ready_after_stall", {63'd0, op_ready}, 64'd1);
    push_exp(4, 32'hCAFE_0001, 32'd0, lat);
    tick();
    op_valid = 1'b0;
    mf_req = 1'b0;
    repeat (2) tick();

    // Asynchronous reset mid-MUL discards the op.
    op_valid = 1'b1;
    op_code  = 3'd0;
    op_a     = 32'h1234_5678;
    op_b     = 32'h9ABC_DEF0;
    tick();
    op_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_busy", {63'd0, busy}, 64'd0);
    check("async_rst_wen", {62'd0, hi_wen, lo_wen}, 64'd0);
    check("async_rst_wdata", {hi_wdata, lo_wdata}, 64'd0);
    tick();
    rst = 1'b0;
    repeat (MUL_LAT + 3) tick();
    @(negedge clk);
    check("ready_after_rst", {63'd0, op_ready}, 64'd1);

    // Randomized ops, including reserved opcodes and edge operands.
    for (int n = 0; n < 40; n++) begin
      op = int'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 50); b = $urandom_range(1, 9); end
        default: ;
      endcase
      if (op >= 6) begin
        op_valid = 1'b1;
        op_code  = 3'(op);
        op_a     = a;
        tick();
        op_valid = 1'b0;
        @(negedge clk);
        check("reserved_not_accepted", {63'd0, op_ready}, 64'd1);
      end else begin
        issue(op, a, b);
      end
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (5) tick();
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
